// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first unsigned subtractor: diff = a - b over WIDTH cycles,
// one difference/borrow stage plus a borrow flip-flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic d_bit;
  logic bout;

  assign d_bit = a_q[0] ^ b_q[0] ^ bin_q;
  assign bout  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned; that is what keeps this block from inferring latches.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Result fills from the top so the first (LSB) bit ends up at bit 0.
        res_d = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bin_d = bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        done_d   = 1'b1;
        diff_d   = res_q;
        borrow_d = bin_q;
        state_d  = S_IDLE;
        // Back-to-back: a start here is accepted just as in IDLE.
        if (start) begin
          a_d     = a;
          b_d     = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random
// operands for WIDTH=8 and WIDTH=1 against an arithmetic reference.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic [0:0] a1 = '0, b1 = '0, diff1;
  logic       busy8, done8, borrow8;
  logic       busy1, done1, borrow1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Launches one operation on the WIDTH=w instance and checks busy length,
  // done timing, result hold during RUN, and the final result.
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input bit mid_start);
    logic [7:0] mask, ea, eb, exp_d, prev_d, cur_d;
    logic       exp_b;
    int         busy_n, done_n, done_at;
    bit         changed;
    mask  = (w == 8) ? 8'hFF : 8'h01;
    ea    = av & mask;
    eb    = bv & mask;
    exp_d = (ea - eb) & mask;
    exp_b = (ea < eb);
    prev_d = (w == 8) ? diff8 : {7'b0, diff1};
    if (w == 8) begin a8 = av; b8 = bv; start8 = 1'b1; end
    else begin a1 = av[0]; b1 = bv[0]; start1 = 1'b1; end
    @(posedge clk);
    #1;
    start8 = 1'b0;
    start1 = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; changed = 0;
    for (int idx = 0; idx <= w + 3; idx++) begin
      @(negedge clk);
      cur_d = (w == 8) ? diff8 : {7'b0, diff1};
      if ((w == 8) ? busy8 : busy1) busy_n++;
      if ((w == 8) ? done8 : done1) begin done_n++; done_at = idx; end
      if (idx < w + 1 && cur_d != prev_d) changed = 1;
      if (mid_start && idx == 2) begin a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1; end
      if (mid_start && idx == 3) start8 = 1'b0;
    end
    check("busy_cycles", busy_n, w);
    check("done_count", done_n, 1);
    check("done_latency", done_at, w + 1);
    check("diff_held_in_run", {31'b0, changed}, 32'd0);
    check("diff", (w == 8) ? diff8 : {7'b0, diff1}, exp_d);
    check("borrow", (w == 8) ? borrow8 : borrow1, exp_b);
  endtask

  initial begin
    int  done_cnt;
    bit  stable_bad, seen_done, seen_busy;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_borrow", borrow8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(8, 8'h5A, 8'h23, 0);
    run_op(8, 8'h00, 8'h01, 0);
    run_op(8, 8'h80, 8'h80, 0);
    run_op(8, 8'hFF, 8'h00, 0);
    run_op(8, 8'h10, 8'h01, 1);
    run_op(1, 8'h01, 8'h00, 0);
    run_op(1, 8'h00, 8'h01, 0);

    // Asynchronous reset mid-RUN, between clock edges.
    a8 = 8'h77; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy8, 0);
    check("async_rst_done", done8, 0);
    check("async_rst_diff", diff8, 0);
    check("async_rst_borrow", borrow8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0; seen_busy = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) seen_done = 1;
      if (busy8) seen_busy = 1;
    end
    check("no_done_after_rst", {31'b0, seen_done}, 0);
    check("no_busy_after_rst", {31'b0, seen_busy}, 0);

    // Back-to-back with start held high.
    a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    @(posedge clk);
    #1 a8 = 8'h03; b8 = 8'h05;
    done_cnt = 0; stable_bad = 0;
    for (int idx = 0; idx <= 18; idx++) begin
      @(negedge clk);
      if (done8) done_cnt++;
      if (idx == 9) begin
        check("b2b_done1", done8, 1);
        check("b2b_diff1", diff8, 8'h02);
        check("b2b_borrow1", borrow8, 0);
      end
      if (idx == 10) check("b2b_done_single", done8, 0);
      if (idx >= 10 && idx <= 17 && diff8 != 8'h02) stable_bad = 1;
      if (idx == 18) begin
        check("b2b_done2", done8, 1);
        check("b2b_diff2", diff8, 8'hFE);
        check("b2b_borrow2", borrow8, 1);
        start8 = 1'b0;
      end
    end
    check("b2b_done_count", done_cnt, 2);
    check("b2b_diff_stable", {31'b0, stable_bad}, 0);
    repeat (12) @(negedge clk);

    // Random regression for both widths.
    for (int i = 0; i < 1000; i++)
      run_op(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 1000; i++)
      run_op(1, 8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
